burst_addrgen: RTL and testbench

BURST_ADDRGEN -- requirements
Module: burst_addrgen

---
 rtl/burst_addrgen.sv | 116 +++++++++++
 tb/tb_burst_addrgen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_addrgen.sv
// Burst address generator: issues len addresses from base in stride steps, with optional
// circular addressing over [0, wrap_limit], valid/ready handshake, abort and done pulse.
module burst_addrgen #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned LEN_WIDTH    = 4,
    parameter int unsigned STRIDE_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base,
    input  logic [LEN_WIDTH-1:0]    len,
    input  logic [STRIDE_WIDTH-1:0] stride,
    input  logic                    wrap_en,
    input  logic [ADDR_WIDTH-1:0]   wrap_limit,
    input  logic                    abort,
    output logic [ADDR_WIDTH-1:0]   addr,
    output logic                    addr_valid,
    input  logic                    addr_ready,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
    logic [STRIDE_WIDTH-1:0] stride_q, stride_d;
    logic                    wrap_en_q, wrap_en_d;
    logic [ADDR_WIDTH-1:0]   wrap_limit_q, wrap_limit_d;
    logic                    done_q, done_d;

    logic [ADDR_WIDTH:0]     sum;
    logic [ADDR_WIDTH-1:0]   addr_next;

    // The wrapped result always fits in ADDR_WIDTH bits for legal bursts, so the
    // subtraction can be done modulo 2^ADDR_WIDTH.
    always_comb begin
        sum = {1'b0, addr_q} + (ADDR_WIDTH+1)'(stride_q);
        if (wrap_en_q && (sum > {1'b0, wrap_limit_q})) begin
            addr_next = sum[ADDR_WIDTH-1:0] - wrap_limit_q - ADDR_WIDTH'(1);
        end else begin
            addr_next = sum[ADDR_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        stride_d     = stride_q;
        wrap_en_d    = wrap_en_q;
        wrap_limit_d = wrap_limit_q;
        done_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (len != '0) begin
                        state_d      = StRun;
                        addr_d       = base;
                        remaining_d  = len;
                        stride_d     = stride;
                        wrap_en_d    = wrap_en;
                        wrap_limit_d = wrap_limit;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (abort) begin
                    state_d     = StIdle;
                    remaining_d = '0;
                end else if (addr_ready) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        // Last beat: addr keeps the final issued value.
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = addr_next;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            remaining_q  <= '0;
            stride_q     <= '0;
            wrap_en_q    <= 1'b0;
            wrap_limit_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            stride_q     <= stride_d;
            wrap_en_q    <= wrap_en_d;
            wrap_limit_q <= wrap_limit_d;
            done_q       <= done_d;
        end
    end

    assign addr       = addr_q;
    assign addr_valid = (state_q == StRun);
    assign busy       = (state_q == StRun);
    assign done       = done_q;

endmodule

// File: tb/tb_burst_addrgen.sv
// Bench for burst_addrgen: transaction-level address-list model checked every cycle,
// plus directed bursts with literal expected addresses.
module tb_burst_addrgen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] base = '0;
    logic [3:0] len = '0;
    logic [3:0] stride = '0;
    logic       wrap_en = 1'b0;
    logic [7:0] wrap_limit = '0;
    logic       abort = 1'b0;
    logic [7:0] addr;
    logic       addr_valid;
    logic       addr_ready = 1'b1;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    burst_addrgen #(
        .ADDR_WIDTH  (8),
        .LEN_WIDTH   (4),
        .STRIDE_WIDTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base      (base),
        .len       (len),
        .stride    (stride),
        .wrap_en   (wrap_en),
        .wrap_limit(wrap_limit),
        .abort     (abort),
        .addr      (addr),
        .addr_valid(addr_valid),
        .addr_ready(addr_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: a burst is the list of addresses it must issue; beats pop the list.
    logic [7:0] exp_q[$];
    bit         exp_active = 0;
    bit         exp_done = 0;
    bit         exp_known = 0;
    bit         model_init = 0;
    logic [7:0] exp_addr = '0;

    always @(posedge clk) begin
        bit         new_done;
        int         a;
        int         s;
        logic [7:0] last;
        new_done = 0;
        if (rst) begin
            exp_active = 0;
            exp_q.delete();
            exp_addr   = '0;
            exp_known  = 1;
            model_init = 1;
        end else if (exp_active) begin
            if (abort) begin
                exp_active = 0;
                exp_q.delete();
                exp_known = 0;
            end else if (addr_ready) begin
                last = exp_q.pop_front();
                if (exp_q.size() == 0) begin
                    exp_active = 0;
                    new_done   = 1;
                    exp_addr   = last;
                end else begin
                    exp_addr = exp_q[0];
                end
            end
        end else if (start) begin
            if (len != 0) begin
                a = int'(base);
                for (int k = 0; k < int'(len); k++) begin
                    exp_q.push_back(a[7:0]);
                    s = a + int'(stride);
                    if (wrap_en) begin
                        if (s > int'(wrap_limit)) s = s - (int'(wrap_limit) + 1);
                    end else begin
                        s = s % 256;
                    end
                    a = s;
                end
                exp_active = 1;
                exp_addr   = base;
                exp_known  = 1;
            end else begin
                new_done = 1;
            end
        end
        if (model_init) exp_done = new_done;
    end

    always @(negedge clk) begin
        if (model_init) begin
            check("addr_valid", int'(addr_valid), int'(exp_active));
            check("busy", int'(busy), int'(exp_active));
            check("done", int'(done), int'(exp_done));
            if (exp_known) check("addr", int'(addr), int'(exp_addr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [7:0] b, input logic [3:0] l, input logic [3:0] st,
                      input logic w, input logic [7:0] wl);
        start = 1'b1; base = b; len = l; stride = st; wrap_en = w; wrap_limit = wl;
        tick();
        start = 1'b0;
    endtask

    logic [7:0] got[$];
    int         dones;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("reset addr", int'(addr), 0);
        check("reset valid", int'(addr_valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        tick();

        // Linear burst
        go(8'h10, 4'd4, 4'd2, 1'b0, 8'h00);
        check("lin a0", int'(addr), 'h10); check("lin v0", int'(addr_valid), 1);
        tick(); check("lin a1", int'(addr), 'h12);
        tick(); check("lin a2", int'(addr), 'h14);
        tick(); check("lin a3", int'(addr), 'h16);
        tick(); check("lin valid end", int'(addr_valid), 0); check("lin done", int'(done), 1);
        check("lin addr hold", int'(addr), 'h16);
        tick(); check("lin done pulse", int'(done), 0);

        // Wrap burst
        go(8'd5, 4'd5, 4'd3, 1'b1, 8'd7);
        check("wrap a0", int'(addr), 5);
        tick(); check("wrap a1", int'(addr), 0);
        tick(); check("wrap a2", int'(addr), 3);
        tick(); check("wrap a3", int'(addr), 6);
        tick(); check("wrap a4", int'(addr), 1);
        tick(); check("wrap done", int'(done), 1);
        tick();

        // Backpressure: ready low on alternate cycles
        go(8'h10, 4'd4, 4'd2, 1'b0, 8'h00);
        got.delete();
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            addr_ready = c[0];
            if (addr_valid && addr_ready) got.push_back(addr);
            if (done) begin
                dones++;
                check("bp done after 4th", got.size(), 4);
            end
            tick();
        end
        addr_ready = 1'b1;
        check("bp beats", got.size(), 4);
        check("bp dones", dones, 1);
        for (int i = 0; i < 4 && i < got.size(); i++) check("bp addr", int'(got[i]), 'h10 + 2 * i);

        // Empty burst
        go(8'h33, 4'd0, 4'd1, 1'b0, 8'h00);
        check("empty valid", int'(addr_valid), 0); check("empty done", int'(done), 1);
        tick(); check("empty done pulse", int'(done), 0);

        // Overflow without wrap
        go(8'hFE, 4'd2, 4'd3, 1'b0, 8'h00);
        check("ovf a0", int'(addr), 'hFE);
        tick(); check("ovf a1", int'(addr), 'h01);
        tick(); check("ovf done", int'(done), 1);
        tick();

        // Abort in the 2nd beat cycle
        go(8'h00, 4'd8, 4'd1, 1'b0, 8'h00);
        tick(); check("abort a1", int'(addr), 1);
        abort = 1'b1;
        tick(); abort = 1'b0;
        check("abort valid", int'(addr_valid), 0); check("abort done", int'(done), 0);
        tick(); check("abort no done", int'(done), 0);
        abort = 1'b1;
        tick(); abort = 1'b0;
        check("idle abort", int'(addr_valid), 0);

        // Reset mid-burst, with start held to show rst wins
        go(8'h40, 4'd8, 4'd1, 1'b0, 8'h00);
        tick();
        rst = 1'b1; start = 1'b1;
        tick();
        check("rst addr", int'(addr), 0); check("rst valid", int'(addr_valid), 0);
        check("rst busy", int'(busy), 0); check("rst done", int'(done), 0);
        rst = 1'b0; start = 1'b0;
        tick(); check("rst no done", int'(done), 0);

        // Back-to-back, with an ignored start during RUN
        go(8'h20, 4'd2, 4'd1, 1'b0, 8'h00);
        start = 1'b1; base = 8'h80; len = 4'd3; stride = 4'd4;
        check("b2b a0", int'(addr), 'h20);
        tick(); check("b2b a1", int'(addr), 'h21);
        tick(); check("b2b done", int'(done), 1);
        base = 8'h40;
        tick(); start = 1'b0;
        check("b2b second a0", int'(addr), 'h40); check("b2b second valid", int'(addr_valid), 1);
        tick(); check("b2b second a1", int'(addr), 'h44);
        tick(); check("b2b second a2", int'(addr), 'h48);
        tick(); check("b2b second done", int'(done), 1);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
